game_state_controller: RTL and testbench

//  Parametrised game-rule engine: owns game_state, score, lives, dot/big-dot tilemaps, frightened mode.

---
 rtl/game_state_controller_pkg.sv | 26 ++
 rtl/game_state_controller_if.sv | 46 ++++
 rtl/game_state_controller_pixel_to_tile.sv | 34 +++
 rtl/game_state_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_game_state_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_state_controller_pkg.sv
// Shared game-rule types and constants for the game state controller slice.
// Latency: none (declarations only).
// Backpressure: none.
package game_state_controller_pkg;

    // Codes seen by the renderer; values are part of the external contract.
    typedef enum logic [2:0] {
        GAME_STATE_IDLE    = 3'd0,
        GAME_STATE_PLAYING = 3'd1,
        GAME_STATE_DYING   = 3'd2,
        GAME_STATE_WON     = 3'd3,
        GAME_STATE_OVER    = 3'd4
    } game_state_e;

    localparam int unsigned DOT_PTS          = 10;
    localparam int unsigned BIG_PTS          = 50;
    localparam int unsigned GHOST_BASE       = 200;
    localparam int unsigned EXTRA_LIFE_SCORE = 10000;
    localparam int unsigned MAX_LIVES        = 7;

    // Ghost value doubles with each ghost eaten in one frightened period.
    function automatic int unsigned ghost_pts(input logic [1:0] chain);
        return GHOST_BASE << chain;
    endfunction

endpackage

// File: rtl/game_state_controller_if.sv
// Bundle between actor controllers, the game rule engine and the renderer.
// Latency: none (wiring only).
// Backpressure: none; tick is a free-running strobe, outputs are level state.
// master: drives positions, tick/start and init maps; slave: the rule engine.
interface game_state_controller_if
    import game_state_controller_pkg::*;
#(
    parameter int GHOST_NUM = 4,
    parameter int TILE_ROWS = 24,
    parameter int TILE_COLS = 32,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SCORE_W   = 16
);
    localparam int TILE_N = TILE_ROWS * TILE_COLS;

    logic                   tick;
    logic                   start;
    logic [X_W-1:0]         player_x;
    logic [Y_W-1:0]         player_y;
    logic [GHOST_NUM*X_W-1:0] ghost_x;
    logic [GHOST_NUM*Y_W-1:0] ghost_y;
    logic [TILE_N-1:0]      dots_init;
    logic [TILE_N-1:0]      big_dots_init;
    logic [TILE_N-1:0]      tilemap_dots;
    logic [TILE_N-1:0]      tilemap_big_dots;
    logic [SCORE_W-1:0]     score;
    logic [2:0]             lives;
    game_state_e            game_state;
    logic                   frightened;
    logic [GHOST_NUM-1:0]   ghost_eaten;
    logic                   char_reset;

    modport master (
        output tick, start, player_x, player_y, ghost_x, ghost_y, dots_init, big_dots_init,
        input  tilemap_dots, tilemap_big_dots, score, lives, game_state, frightened,
               ghost_eaten, char_reset
    );

    modport slave (
        input  tick, start, player_x, player_y, ghost_x, ghost_y, dots_init, big_dots_init,
        output tilemap_dots, tilemap_big_dots, score, lives, game_state, frightened,
               ghost_eaten, char_reset
    );

endinterface

// File: rtl/game_state_controller_pixel_to_tile.sv
// Maps a top-left pixel position to the tile under the sprite centre.
// Latency: combinational.
// Backpressure: none.
// Ports: pix_x/pix_y in; row/col/idx (row*TILE_COLS+col) out; in_range low when off-map.
module game_state_controller_pixel_to_tile #(
    parameter int TILE_ROWS = 24,
    parameter int TILE_COLS = 32,
    parameter int TILE_SIZE = 20,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int IDX_W     = 10
) (
    input  logic [X_W-1:0]   pix_x,
    input  logic [Y_W-1:0]   pix_y,
    output logic [Y_W-1:0]   row,
    output logic [X_W-1:0]   col,
    output logic [IDX_W-1:0] idx,
    output logic             in_range
);
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    // One extra bit so the centre offset cannot wrap near the right/bottom edge.
    assign x_sum = {1'b0, pix_x} + (X_W+1)'(TILE_SIZE / 2);
    assign y_sum = {1'b0, pix_y} + (Y_W+1)'(TILE_SIZE / 2);

    // The quotient is never wider than the pixel coordinate for TILE_SIZE >= 2.
    assign col = X_W'(x_sum / (X_W+1)'(TILE_SIZE));
    assign row = Y_W'(y_sum / (Y_W+1)'(TILE_SIZE));

    assign in_range = (32'(row) < TILE_ROWS) && (32'(col) < TILE_COLS);
    assign idx      = IDX_W'(row) * IDX_W'(TILE_COLS) + IDX_W'(col);

endmodule

// File: rtl/game_state_controller.sv
// Game rule engine: game state, score, lives, dot maps, frightened mode and ghost eating.
// Latency: rules evaluate on the clk edge with tick=1; outputs valid the following clk.
// Backpressure: none; every tick is consumed, pulses last exactly one clk.
// Ports: clk, reset (async, active-high), bus (slave side of game_state_controller_if).
// Optional: define GAME_EXTRA_LIFE_EN for a single bonus life when score first reaches 10000.
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int GHOST_NUM    = 4,
    parameter int TILE_ROWS    = 24,
    parameter int TILE_COLS    = 32,
    parameter int TILE_SIZE    = 20,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int SCORE_W      = 16,
    parameter int START_LIVES  = 3,
    parameter int COLL_DIST    = 12,
    parameter int FRIGHT_TICKS = 500,
    parameter int DEATH_TICKS  = 100
) (
    input  logic clk,
    input  logic reset,
    game_state_controller_if.slave bus
);
    localparam int TILE_N   = TILE_ROWS * TILE_COLS;
    localparam int IDX_W    = $clog2(TILE_N);
    localparam int FRIGHT_W = $clog2(FRIGHT_TICKS + 1);
    localparam int DEATH_W  = $clog2(DEATH_TICKS + 1);

    game_state_e          state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [2:0]           lives_q, lives_d;
    logic [TILE_N-1:0]    dots_q, dots_d;
    logic [TILE_N-1:0]    big_q, big_d;
    logic [FRIGHT_W-1:0]  fright_q, fright_d;
    logic [1:0]           chain_q, chain_d;
    logic [GHOST_NUM-1:0] mask_q, mask_d;
    logic [DEATH_W-1:0]   death_q, death_d;
    logic [GHOST_NUM-1:0] eaten_q, eaten_d;
    logic                 char_reset_q, char_reset_d;
`ifdef GAME_EXTRA_LIFE_EN
    logic                 bonus_q, bonus_d;
`endif

    // Player tile lookup; row/col are for other consumers and not needed here.
    logic [Y_W-1:0]   unused_row;
    logic [X_W-1:0]   unused_col;
    logic [IDX_W-1:0] p_idx;
    logic             p_valid;

    game_state_controller_pixel_to_tile #(
        .TILE_ROWS (TILE_ROWS),
        .TILE_COLS (TILE_COLS),
        .TILE_SIZE (TILE_SIZE),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .IDX_W     (IDX_W)
    ) u_player_tile (
        .pix_x    (bus.player_x),
        .pix_y    (bus.player_y),
        .row      (unused_row),
        .col      (unused_col),
        .idx      (p_idx),
        .in_range (p_valid)
    );

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input int unsigned pts);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W+1)'(pts);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [X_W-1:0] abs_dx(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [Y_W-1:0] abs_dy(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    logic [GHOST_NUM-1:0] coll;

    always_comb begin
        coll = '0;
        for (int i = 0; i < GHOST_NUM; i++) begin
            coll[i] = (32'(abs_dx(bus.ghost_x[i*X_W +: X_W], bus.player_x)) < COLL_DIST) &&
                      (32'(abs_dy(bus.ghost_y[i*Y_W +: Y_W], bus.player_y)) < COLL_DIST);
        end
    end

    logic                 dot_hit, big_hit, fright_live, lethal, won;
    logic [GHOST_NUM-1:0] mask_cur, edible, eat_oh;

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        dots_d       = dots_q;
        big_d        = big_q;
        fright_d     = fright_q;
        chain_d      = chain_q;
        mask_d       = mask_q;
        death_d      = death_q;
        eaten_d      = '0;
        char_reset_d = 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
        bonus_d      = bonus_q;
`endif
        dot_hit     = p_valid && dots_q[p_idx];
        big_hit     = p_valid && big_q[p_idx];
        // A big dot eaten this tick makes ghosts edible in the same tick.
        fright_live = big_hit || (fright_q != '0);
        mask_cur    = big_hit ? '0 : mask_q;
        edible      = fright_live ? (coll & ~mask_cur) : '0;
        lethal      = |(coll & ~edible);
        won         = 1'b0;
        eat_oh      = '0;

        if (bus.tick) begin
            case (state_q)
                GAME_STATE_IDLE, GAME_STATE_WON, GAME_STATE_OVER: begin
                    if (bus.start) begin
                        dots_d       = bus.dots_init;
                        big_d        = bus.big_dots_init;
                        score_d      = '0;
                        lives_d      = 3'(START_LIVES);
                        fright_d     = '0;
                        chain_d      = '0;
                        mask_d       = '0;
                        death_d      = '0;
                        char_reset_d = 1'b1;
                        state_d      = GAME_STATE_PLAYING;
`ifdef GAME_EXTRA_LIFE_EN
                        bonus_d      = 1'b0;
`endif
                    end
                end

                GAME_STATE_PLAYING: begin
                    if (dot_hit) begin
                        dots_d[p_idx] = 1'b0;
                        score_d       = sat_add(score_d, DOT_PTS);
                    end
                    if (big_hit) begin
                        big_d[p_idx] = 1'b0;
                        score_d      = sat_add(score_d, BIG_PTS);
                        fright_d     = FRIGHT_W'(FRIGHT_TICKS);
                    end else if (fright_q != '0) begin
                        fright_d = fright_q - FRIGHT_W'(1);
                    end
                    chain_d = big_hit ? 2'd0 : chain_q;
                    mask_d  = mask_cur;

                    // Only the lowest-index edible ghost is eaten; a lethal touch blocks eating.
                    if (!lethal) begin
                        for (int i = GHOST_NUM - 1; i >= 0; i--) begin
                            if (edible[i]) begin
                                eat_oh    = '0;
                                eat_oh[i] = 1'b1;
                            end
                        end
                        if (eat_oh != '0) begin
                            score_d = sat_add(score_d, ghost_pts(chain_d));
                            chain_d = (chain_d == 2'd3) ? 2'd3 : chain_d + 2'd1;
                            mask_d  = mask_d | eat_oh;
                            eaten_d = eat_oh;
                        end
                    end

`ifdef GAME_EXTRA_LIFE_EN
                    if (!bonus_q && (32'(score_q) < EXTRA_LIFE_SCORE) &&
                        (32'(score_d) >= EXTRA_LIFE_SCORE)) begin
                        bonus_d = 1'b1;
                        if (lives_d != 3'(MAX_LIVES)) lives_d = lives_d + 3'd1;
                    end
`endif

                    // Clearing the board wins outright, even with a lethal ghost overlapping.
                    won = (dots_d == '0) && (big_d == '0);
                    if (won) begin
                        state_d = GAME_STATE_WON;
                    end else if (lethal) begin
                        lives_d  = (lives_d != 3'd0) ? lives_d - 3'd1 : 3'd0;
                        fright_d = '0;
                        death_d  = '0;
                        state_d  = GAME_STATE_DYING;
                    end
                end

                GAME_STATE_DYING: begin
                    if (death_q == DEATH_W'(DEATH_TICKS - 1)) begin
                        death_d = '0;
                        if (lives_q == 3'd0) begin
                            state_d = GAME_STATE_OVER;
                        end else begin
                            state_d      = GAME_STATE_PLAYING;
                            char_reset_d = 1'b1;
                        end
                    end else begin
                        death_d = death_q + DEATH_W'(1);
                    end
                end

                default: state_d = GAME_STATE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= GAME_STATE_IDLE;
            score_q      <= '0;
            lives_q      <= '0;
            dots_q       <= '0;
            big_q        <= '0;
            fright_q     <= '0;
            chain_q      <= '0;
            mask_q       <= '0;
            death_q      <= '0;
            eaten_q      <= '0;
            char_reset_q <= 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
            bonus_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            dots_q       <= dots_d;
            big_q        <= big_d;
            fright_q     <= fright_d;
            chain_q      <= chain_d;
            mask_q       <= mask_d;
            death_q      <= death_d;
            eaten_q      <= eaten_d;
            char_reset_q <= char_reset_d;
`ifdef GAME_EXTRA_LIFE_EN
            bonus_q      <= bonus_d;
`endif
        end
    end

    assign bus.game_state       = state_q;
    assign bus.score            = score_q;
    assign bus.lives            = lives_q;
    assign bus.tilemap_dots     = dots_q;
    assign bus.tilemap_big_dots = big_q;
    assign bus.frightened       = (fright_q != '0);
    assign bus.ghost_eaten      = eaten_q;
    assign bus.char_reset       = char_reset_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: vector tables plus multi-tick sequences.
// Latency: each applied tick is checked one clk later, on the falling edge.
// Backpressure: none.
module tb_game_state_controller;
    import game_state_controller_pkg::*;

    localparam int GN = 4, TR = 24, TC = 32, TS = 20, XW = 10, YW = 9, SW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_state_controller_if #(.GHOST_NUM(GN), .TILE_ROWS(TR), .TILE_COLS(TC),
                               .X_W(XW), .Y_W(YW), .SCORE_W(SW)) bus();

    game_state_controller #(.GHOST_NUM(GN), .TILE_ROWS(TR), .TILE_COLS(TC), .TILE_SIZE(TS),
                            .X_W(XW), .Y_W(YW), .SCORE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        int         prow;
        int         pcol;
        logic [3:0] gon;     // ghosts placed on top of the player
        int         st;
        int         sc;
        int         lv;
        int         fr;
        int         eat;
        int         cr;
        int         nd;      // remaining dot count
        int         nb;      // remaining big-dot count
    } vec_t;

    vec_t t1[8];
    vec_t t2[4];

    int total = 0;
    int bad   = 0;
    int es, el, prev;
    bit bonus;

    function automatic int tidx(input int r, input int c);
        return r * TC + c;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pos(input int r, input int c, input logic [3:0] gon);
        bus.player_x = XW'(c * TS);
        bus.player_y = YW'(r * TS);
        for (int g = 0; g < GN; g++) begin
            bus.ghost_x[g*XW +: XW] = gon[g] ? XW'(c * TS) : XW'(600);
            bus.ghost_y[g*YW +: YW] = gon[g] ? YW'(r * TS) : YW'(440);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        bus.start = v.start;
        set_pos(v.prow, v.pcol, v.gon);
        do_tick();
        bus.start = 1'b0;
        check({tag, " state"}, int'(bus.game_state), v.st);
        check({tag, " score"}, int'(bus.score), v.sc);
        check({tag, " lives"}, int'(bus.lives), v.lv);
        check({tag, " fright"}, int'(bus.frightened), v.fr);
        check({tag, " eaten"}, int'(bus.ghost_eaten), v.eat);
        check({tag, " char_reset"}, int'(bus.char_reset), v.cr);
        check({tag, " ndots"}, $countones(bus.tilemap_dots), v.nd);
        check({tag, " nbig"}, $countones(bus.tilemap_big_dots), v.nb);
    endtask

    // Saturation run: bench keeps its own running score/lives model.
    task automatic sat_tick(input int r, input int c, input logic [3:0] gon,
                            input int add, input int eat);
        set_pos(r, c, gon);
        do_tick();
        prev = es;
        es   = (es + add > 65535) ? 65535 : es + add;
`ifdef GAME_EXTRA_LIFE_EN
        if (!bonus && prev < 10000 && es >= 10000) begin
            bonus = 1'b1;
            if (el < 7) el++;
        end
`endif
        check($sformatf("sat score r%0d c%0d g%0h", r, c, gon), int'(bus.score), es);
        check($sformatf("sat lives r%0d c%0d g%0h", r, c, gon), int'(bus.lives), el);
        check($sformatf("sat eaten r%0d c%0d g%0h", r, c, gon), int'(bus.ghost_eaten), eat);
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        set_pos(0, 0, 4'b0000);
        bus.dots_init     = '0;
        bus.big_dots_init = '0;
        bus.dots_init[tidx(5, 3)]     = 1'b1;
        bus.dots_init[tidx(5, 4)]     = 1'b1;
        bus.dots_init[tidx(5, 5)]     = 1'b1;
        bus.big_dots_init[tidx(6, 3)] = 1'b1;

        //        start r  c  gon      state                      score lv fr eat cr nd nb
        t1[0] = '{1'b1, 0, 0, 4'b0000, int'(GAME_STATE_PLAYING),     0, 3, 0, 0, 1, 3, 1};
        t1[1] = '{1'b0, 5, 3, 4'b0000, int'(GAME_STATE_PLAYING),    10, 3, 0, 0, 0, 2, 1};
        t1[2] = '{1'b0, 6, 3, 4'b0000, int'(GAME_STATE_PLAYING),    60, 3, 1, 0, 0, 2, 0};
        t1[3] = '{1'b0, 6, 3, 4'b0011, int'(GAME_STATE_PLAYING),   260, 3, 1, 1, 0, 2, 0};
        t1[4] = '{1'b0, 6, 3, 4'b0010, int'(GAME_STATE_PLAYING),   660, 3, 1, 2, 0, 2, 0};
        t1[5] = '{1'b0, 6, 3, 4'b0100, int'(GAME_STATE_PLAYING),  1460, 3, 1, 4, 0, 2, 0};
        t1[6] = '{1'b0, 6, 3, 4'b1000, int'(GAME_STATE_PLAYING),  3060, 3, 1, 8, 0, 2, 0};
        t1[7] = '{1'b0, 6, 3, 4'b0001, int'(GAME_STATE_DYING),    3060, 2, 0, 0, 0, 2, 0};

        t2[0] = '{1'b0, 5, 4, 4'b0000, int'(GAME_STATE_PLAYING),  3070, 2, 0, 0, 0, 1, 0};
        t2[1] = '{1'b0, 5, 5, 4'b0001, int'(GAME_STATE_WON),      3080, 2, 0, 0, 0, 0, 0};
        t2[2] = '{1'b0, 5, 5, 4'b0001, int'(GAME_STATE_WON),      3080, 2, 0, 0, 0, 0, 0};
        t2[3] = '{1'b1, 0, 0, 4'b0000, int'(GAME_STATE_PLAYING),     0, 3, 0, 0, 1, 3, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst state", int'(bus.game_state), int'(GAME_STATE_IDLE));
        check("rst score", int'(bus.score), 0);
        check("rst lives", int'(bus.lives), 0);
        check("rst ndots", $countones(bus.tilemap_dots), 0);
        check("rst nbig", $countones(bus.tilemap_big_dots), 0);
        check("rst fright", int'(bus.frightened), 0);
        check("rst eaten", int'(bus.ghost_eaten), 0);
        check("rst char_reset", int'(bus.char_reset), 0);

        for (int k = 0; k < 8; k++) begin
            apply(t1[k], $sformatf("t1[%0d]", k));
            if (k == 1) begin
                check("dot 5,3 cleared", int'(bus.tilemap_dots[tidx(5, 3)]), 0);
                check("dot 5,4 kept", int'(bus.tilemap_dots[tidx(5, 4)]), 1);
            end
        end

        // Death timer: 99 ticks still dying, the 100th respawns.
        set_pos(6, 3, 4'b0000);
        repeat (99) do_tick();
        check("dying 99 state", int'(bus.game_state), int'(GAME_STATE_DYING));
        check("dying 99 char_reset", int'(bus.char_reset), 0);
        do_tick();
        check("respawn state", int'(bus.game_state), int'(GAME_STATE_PLAYING));
        check("respawn char_reset", int'(bus.char_reset), 1);
        check("respawn lives", int'(bus.lives), 2);
        check("respawn score", int'(bus.score), 3060);

        for (int k = 0; k < 4; k++) apply(t2[k], $sformatf("t2[%0d]", k));

        // Ghost parked on the player: each respawn is immediately lethal again.
        for (int k = 0; k < 3; k++) begin
            set_pos(0, 0, 4'b0001);
            do_tick();
            check($sformatf("lethal%0d state", k), int'(bus.game_state), int'(GAME_STATE_DYING));
            check($sformatf("lethal%0d lives", k), int'(bus.lives), 2 - k);
            repeat (99) do_tick();
            check($sformatf("lethal%0d still dying", k), int'(bus.game_state), int'(GAME_STATE_DYING));
            do_tick();
            if (k < 2) begin
                check($sformatf("lethal%0d respawn", k), int'(bus.game_state), int'(GAME_STATE_PLAYING));
                check($sformatf("lethal%0d char_reset", k), int'(bus.char_reset), 1);
            end else begin
                check("over state", int'(bus.game_state), int'(GAME_STATE_OVER));
                check("over char_reset", int'(bus.char_reset), 0);
                check("over lives", int'(bus.lives), 0);
            end
        end
        do_tick();
        check("over hold", int'(bus.game_state), int'(GAME_STATE_OVER));

        bus.start = 1'b1;
        set_pos(0, 0, 4'b0000);
        do_tick();
        bus.start = 1'b0;
        check("restart state", int'(bus.game_state), int'(GAME_STATE_PLAYING));
        check("restart lives", int'(bus.lives), 3);
        check("restart ndots", $countones(bus.tilemap_dots), 3);

        // No tick: standing on a dot changes nothing.
        set_pos(5, 3, 4'b0000);
        repeat (4) @(negedge clk);
        check("no tick score", int'(bus.score), 0);
        check("no tick ndots", $countones(bus.tilemap_dots), 3);
        do_tick();
        check("tick score", int'(bus.score), 10);
        set_pos(5, 3, 4'b0001);
        do_tick();
        check("pre-reset dying", int'(bus.game_state), int'(GAME_STATE_DYING));
        repeat (10) do_tick();

        // Asynchronous reset between clock edges, mid-DYING.
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async state", int'(bus.game_state), int'(GAME_STATE_IDLE));
        check("async score", int'(bus.score), 0);
        check("async lives", int'(bus.lives), 0);
        check("async ndots", $countones(bus.tilemap_dots), 0);
        @(negedge clk);
        check("async hold state", int'(bus.game_state), int'(GAME_STATE_IDLE));
        check("async hold char_reset", int'(bus.char_reset), 0);
        reset = 1'b0;

        // Saturation layout: 23 big dots on row 10, 3 dots on row 12, one dot never eaten.
        bus.dots_init     = '0;
        bus.big_dots_init = '0;
        for (int c = 0; c < 23; c++) bus.big_dots_init[tidx(10, c)] = 1'b1;
        for (int c = 0; c < 3; c++) bus.dots_init[tidx(12, c)] = 1'b1;
        bus.dots_init[tidx(20, 20)] = 1'b1;
        bus.start = 1'b1;
        set_pos(0, 0, 4'b0000);
        do_tick();
        bus.start = 1'b0;
        check("sat start state", int'(bus.game_state), int'(GAME_STATE_PLAYING));
        check("sat start lives", int'(bus.lives), 3);
        check("sat start char_reset", int'(bus.char_reset), 1);

        es    = 0;
        el    = 3;
        bonus = 1'b0;
        for (int r = 0; r < 22; r++) begin
            sat_tick(10, r, 4'b0000, 50, 0);
            for (int g = 0; g < ((r < 21) ? 4 : 3); g++)
                sat_tick(10, r, 4'(1 << g), 200 << g, 1 << g);
        end
        for (int c = 0; c < 3; c++) sat_tick(12, c, 4'b0000, 10, 0);
        check("score 65530", int'(bus.score), 65530);
        sat_tick(10, 22, 4'b0000, 50, 0);
        check("score saturated", int'(bus.score), 65535);
        check("sat fright", int'(bus.frightened), 1);
        sat_tick(10, 22, 4'b1000, 200, 8);
`ifdef GAME_EXTRA_LIFE_EN
        check("final lives bonus", int'(bus.lives), 4);
`else
        check("final lives", int'(bus.lives), 3);
`endif
        check("sat still playing", int'(bus.game_state), int'(GAME_STATE_PLAYING));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
